// File: rtl/i2c_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// Module   : i2c_ctrl
// Purpose  : I2C master for a PCF8591 AD/DA. Runs one write or read bus
//            transaction per request and pulses i2c_end when done.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module i2c_ctrl #(
  parameter int         SYS_CLK_FREQ = 50_000_000,
  parameter int         SCL_FREQ     = 250_000,
  parameter logic [6:0] DEVICE_ADDR  = 7'b1001_000,
  parameter int         ADDR_NUM     = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        i2c_start,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [15:0] byte_addr,
  input  logic [7:0]  wr_data,
  output logic        i2c_end,
  output logic [7:0]  rd_data,
  output logic        ack_err,
  output logic        busy,
  output logic        i2c_scl,
  inout  wire         i2c_sda
);

  localparam int QTR = SYS_CLK_FREQ / (SCL_FREQ * 4);
  localparam int CW  = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [CW-1:0] QTR_LAST = CW'(QTR - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_DADDR, S_ACK1, S_BADDR_H, S_ACK2, S_BADDR_L, S_ACK3,
    S_WR_DATA, S_ACK4, S_START2, S_RDADDR, S_ACK5, S_RD_DATA, S_NACK, S_STOP
  } state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_qtr;
  logic [2:0]    r_bit;
  logic [15:0]   r_addr;
  logic [7:0]    r_wdata;
  logic [7:0]    r_shift;
  logic          r_op_wr;
  logic          r_sda_smp;
  logic          r_rd_ok;

  logic          w_accept, w_qtick, w_send, w_last_bit, w_nack, w_op_none, w_is_ack;
  logic          w_scl, w_sda_low, w_scl_pulse;
  logic [7:0]    w_tx_byte;

  assign w_accept    = (r_state == S_IDLE) && !busy && i2c_start;
  assign w_qtick     = (r_cnt == QTR_LAST);
  assign w_send      = w_qtick && (r_qtr == 2'd3);
  assign w_last_bit  = (r_bit == 3'd0);
  assign w_nack      = r_sda_smp;
  assign w_op_none   = !wr_en && !rd_en;
  assign w_scl_pulse = r_qtr[0] ^ r_qtr[1];
  assign w_is_ack    = (r_state == S_ACK1) || (r_state == S_ACK2) || (r_state == S_ACK3) ||
                       (r_state == S_ACK4) || (r_state == S_ACK5);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_scl     = 1'b1;
    w_sda_low = 1'b0;
    w_tx_byte = 8'h00;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_START;
      S_START: begin
        w_scl     = (r_qtr != 2'd3);
        w_sda_low = r_qtr[1];
        if (w_qtick && (r_qtr == 2'd0) && w_op_none) w_next = S_STOP;
        else if (w_send)                              w_next = S_DADDR;
      end
      S_START2: begin
        // SCL low first so SDA can be released before the repeated START
        w_scl     = w_scl_pulse;
        w_sda_low = r_qtr[1];
        if (w_send) w_next = S_RDADDR;
      end
      S_DADDR, S_BADDR_H, S_BADDR_L, S_WR_DATA, S_RDADDR: begin
        w_scl = w_scl_pulse;
        case (r_state)
          S_DADDR:   w_tx_byte = {DEVICE_ADDR, 1'b0};
          S_BADDR_H: w_tx_byte = r_addr[15:8];
          S_BADDR_L: w_tx_byte = r_addr[7:0];
          S_WR_DATA: w_tx_byte = r_wdata;
          default:   w_tx_byte = {DEVICE_ADDR, 1'b1};
        endcase
        w_sda_low = !w_tx_byte[r_bit];
        if (w_send && w_last_bit) begin
          case (r_state)
            S_DADDR:   w_next = S_ACK1;
            S_BADDR_H: w_next = S_ACK2;
            S_BADDR_L: w_next = S_ACK3;
            S_WR_DATA: w_next = S_ACK4;
            default:   w_next = S_ACK5;
          endcase
        end
      end
      S_ACK1, S_ACK2, S_ACK3, S_ACK4, S_ACK5: begin
        w_scl = w_scl_pulse;
        if (w_send) begin
          if (w_nack || (r_state == S_ACK4)) w_next = S_STOP;
          else if (r_state == S_ACK1)        w_next = (ADDR_NUM == 2) ? S_BADDR_H : S_BADDR_L;
          else if (r_state == S_ACK2)        w_next = S_BADDR_L;
          else if (r_state == S_ACK3)        w_next = r_op_wr ? S_WR_DATA : S_START2;
          else                               w_next = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        w_scl = w_scl_pulse;
        if (w_send && w_last_bit) w_next = S_NACK;
      end
      S_NACK: begin
        w_scl = w_scl_pulse;
        if (w_send) w_next = S_STOP;
      end
      S_STOP: begin
        w_scl     = (r_qtr != 2'd0);
        w_sda_low = !r_qtr[1];
        if (w_send) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt     <= '0;
      r_qtr     <= 2'd0;
      r_bit     <= 3'd7;
      r_addr    <= 16'h0000;
      r_wdata   <= 8'h00;
      r_shift   <= 8'h00;
      r_op_wr   <= 1'b0;
      r_sda_smp <= 1'b1;
      r_rd_ok   <= 1'b0;
      i2c_end   <= 1'b0;
      rd_data   <= 8'h00;
      ack_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      i2c_end <= 1'b0;
      if (r_state == S_IDLE) r_cnt <= '0;
      else if (w_qtick)      r_cnt <= '0;
      else                   r_cnt <= r_cnt + CW'(1);

      // every state entry restarts the slot and the bit index
      if (w_next != r_state) begin
        r_qtr <= 2'd0;
        r_bit <= 3'd7;
      end else begin
        if (w_qtick) r_qtr <= r_qtr + 2'd1;
        if (w_send)  r_bit <= r_bit - 3'd1;
      end

      if (w_accept) begin
        r_addr  <= byte_addr;
        r_wdata <= wr_data;
        busy    <= 1'b1;
        ack_err <= 1'b0;
        r_rd_ok <= 1'b0;
      end
      if ((r_state == S_START) && (r_qtr == 2'd0) && w_qtick) r_op_wr <= wr_en;
      if (w_qtick && (r_qtr == 2'd2)) begin
        r_sda_smp <= i2c_sda;
        if (r_state == S_RD_DATA) r_shift <= {r_shift[6:0], i2c_sda};
      end
      if (w_send && w_is_ack && w_nack) ack_err <= 1'b1;
      if (w_send && (r_state == S_NACK)) r_rd_ok <= 1'b1;
      if (w_send && (r_state == S_STOP)) begin
        i2c_end <= 1'b1;
        if (r_rd_ok) rd_data <= r_shift;
      end
      if (i2c_end) busy <= 1'b0;
    end
  end

  assign i2c_scl = w_scl;
  assign i2c_sda = w_sda_low ? 1'b0 : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_i2c_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// Module   : tb_i2c_ctrl
// Purpose  : Self-checking bench for i2c_ctrl with a bus-level slave model.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_i2c_ctrl;

  localparam int         SYS_CLK_FREQ = 50_000_000;
  localparam int         SCL_FREQ     = 1_250_000;
  localparam int         ADDR_NUM     = 1;
  localparam logic [6:0] DEV          = 7'b1001_000;
  localparam int         QTR          = SYS_CLK_FREQ / (SCL_FREQ * 4);
  localparam int         SLOT         = 4 * QTR;
  localparam int         EV_S         = 1000;
  localparam int         EV_P         = 1001;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        i2c_start = 1'b0;
  logic        wr_en     = 1'b0;
  logic        rd_en     = 1'b0;
  logic [15:0] byte_addr = 16'h0000;
  logic [7:0]  wr_data   = 8'h00;
  wire         i2c_end;
  wire  [7:0]  rd_data;
  wire         ack_err;
  wire         busy;
  wire         i2c_scl;
  wire         i2c_sda;
  logic        slave_low = 1'b0;

  pullup (i2c_sda);
  assign i2c_sda = slave_low ? 1'b0 : 1'bz;

  i2c_ctrl #(
    .SYS_CLK_FREQ(SYS_CLK_FREQ),
    .SCL_FREQ    (SCL_FREQ),
    .DEVICE_ADDR (DEV),
    .ADDR_NUM    (ADDR_NUM)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .i2c_start(i2c_start),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .byte_addr(byte_addr),
    .wr_data  (wr_data),
    .i2c_end  (i2c_end),
    .rd_data  (rd_data),
    .ack_err  (ack_err),
    .busy     (busy),
    .i2c_scl  (i2c_scl),
    .i2c_sda  (i2c_sda)
  );

  always #10 sys_clk = ~sys_clk;

  // Bus monitor + PCF8591-like slave; events: EV_S, EV_P, or {byte, ack_bit}
  int         ev_q[$];
  int         end_cnt = 0;
  int         cyc = 0, last_rise = 0, scl_period = 0;
  logic [7:0] cfg_rbyte = 8'h00;
  int         cfg_nack_idx = -1;
  logic       p_scl = 1'b1, p_sda = 1'b1;
  logic [8:0] sh = 9'h000;
  int         bitcnt = 0, rbit = 0, txcnt = 0, byte_idx = 0;
  bit         just_done = 0, rd_phase = 0, going_read = 0;

  always @(negedge sys_clk) begin
    logic cs, cd;
    cs = i2c_scl;
    cd = (i2c_sda === 1'b0) ? 1'b0 : 1'b1;
    cyc++;
    if (i2c_end) end_cnt++;
    if (!busy) txcnt = 0;
    if (!sys_rst_n) begin
      slave_low = 1'b0; bitcnt = 0; just_done = 0; rd_phase = 0; going_read = 0;
    end else if (cs && p_scl && p_sda && !cd) begin
      ev_q.push_back(EV_S);
      bitcnt = 0; byte_idx = 0; just_done = 0; rd_phase = 0; going_read = 0;
    end else if (cs && p_scl && !p_sda && cd) begin
      ev_q.push_back(EV_P);
      bitcnt = 0; rd_phase = 0; going_read = 0;
    end else if (!p_scl && cs) begin
      scl_period = cyc - last_rise;
      last_rise  = cyc;
      sh = {sh[7:0], cd};
      bitcnt++;
      if (bitcnt == 9) begin
        ev_q.push_back(int'(sh));
        bitcnt = 0; byte_idx++; just_done = 1;
      end
    end else if (p_scl && !cs) begin
      if (rd_phase && bitcnt >= 1 && bitcnt <= 7) begin
        slave_low = !cfg_rbyte[rbit]; rbit--;
      end else if (rd_phase && bitcnt == 8) begin
        slave_low = 1'b0; rd_phase = 0;
      end else if (bitcnt == 8) begin
        if (txcnt == cfg_nack_idx) slave_low = 1'b0;
        else begin
          slave_low = 1'b1;
          if (byte_idx == 0 && sh[0] && sh[7:1] == DEV) going_read = 1;
        end
        txcnt++;
      end else if (just_done) begin
        slave_low = 1'b0; just_done = 0;
        if (going_read) begin
          going_read = 0; rd_phase = 1; slave_low = !cfg_rbyte[7]; rbit = 6;
        end
      end
    end
    p_scl = cs;
    p_sda = cd;
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: expected bus events, slot count and status from the protocol rules
  int         exp_q[$];
  int         exp_slots;
  bit         exp_nack;
  logic [7:0] exp_rd = 8'h00;

  task automatic build_model(input bit is_rd, input logic [15:0] addr, input logic [7:0] wd,
                             input logic [7:0] rb, input int nack_idx);
    logic [7:0] tx[$];
    int ti;
    exp_q.delete();
    exp_q.push_back(EV_S);
    exp_slots = 1; exp_nack = 0; ti = 0;
    tx.push_back({DEV, 1'b0});
    if (ADDR_NUM == 2) tx.push_back(addr[15:8]);
    tx.push_back(addr[7:0]);
    if (!is_rd) tx.push_back(wd);
    foreach (tx[i]) begin
      if (!exp_nack) begin
        exp_nack = (ti == nack_idx);
        exp_q.push_back(int'({tx[i], exp_nack}));
        exp_slots += 9; ti++;
      end
    end
    if (is_rd && !exp_nack) begin
      exp_q.push_back(EV_S);
      exp_slots += 1;
      exp_nack = (ti == nack_idx);
      exp_q.push_back(int'({DEV, 1'b1, exp_nack}));
      exp_slots += 9;
      if (!exp_nack) begin
        exp_q.push_back(int'({rb, 1'b1}));
        exp_slots += 9;
        exp_rd = rb;
      end
    end
    exp_q.push_back(EV_P);
    exp_slots += 1;
  endtask

  task automatic run_xfer(input bit is_rd, input logic [15:0] addr, input logic [7:0] wd,
                          input logic [7:0] rb, input int nack_idx, input bit poke);
    int n, base, e0;
    bit done;
    build_model(is_rd, addr, wd, rb, nack_idx);
    cfg_rbyte = rb; cfg_nack_idx = nack_idx;
    base = ev_q.size(); e0 = end_cnt;
    @(negedge sys_clk);
    i2c_start = 1'b1; wr_en = !is_rd; rd_en = is_rd; byte_addr = addr; wr_data = wd;
    @(negedge sys_clk);
    i2c_start = 1'b0;
    chk("busy_after_start", busy, 1);
    n = 0; done = 0;
    while (!done && n < 20000) begin
      @(negedge sys_clk);
      n++;
      i2c_start = poke && (n == 1000);
      if (poke && n == 1000) wr_data = ~wd;
      if (i2c_end) done = 1;
    end
    chk("end_timeout", done, 1);
    chk("latency", n, exp_slots * SLOT);
    chk("ack_err", ack_err, exp_nack);
    chk("rd_data", rd_data, exp_rd);
    chk("busy_at_end", busy, 1);
    chk("scl_period", scl_period, SLOT);
    i2c_start = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    @(negedge sys_clk);
    chk("end_width", i2c_end, 0);
    chk("busy_drop", busy, 0);
    repeat (100) @(negedge sys_clk);
    chk("end_count", end_cnt - e0, 1);
    chk("ev_count", ev_q.size() - base, exp_q.size());
    foreach (exp_q[i])
      chk($sformatf("ev%0d", i), (base + i < ev_q.size()) ? ev_q[base + i] : -1, exp_q[i]);
    chk("idle_scl", i2c_scl, 1);
    chk("idle_sda", i2c_sda, 1);
  endtask

  task automatic reset_mid_write();
    int e0;
    e0 = end_cnt;
    cfg_nack_idx = -1;
    @(negedge sys_clk);
    i2c_start = 1'b1; wr_en = 1'b1; byte_addr = 16'h0012; wr_data = 8'h00;
    @(negedge sys_clk);
    i2c_start = 1'b0;
    repeat (21 * SLOT + QTR + 2) @(negedge sys_clk);
    chk("busy_mid_write", busy, 1);
    chk("sda_low_mid_write", i2c_sda, 0);
    sys_rst_n = 1'b0;
    #1;
    chk("rst_scl", i2c_scl, 1);
    chk("rst_sda", i2c_sda, 1);
    chk("rst_busy", busy, 0);
    chk("rst_end", i2c_end, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_ack_err", ack_err, 0);
    exp_rd = 8'h00;
    repeat (4) @(negedge sys_clk);
    sys_rst_n = 1'b1; wr_en = 1'b0;
    repeat (30 * SLOT) @(negedge sys_clk);
    chk("no_end_after_reset", end_cnt - e0, 0);
    chk("idle_after_reset", busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge sys_clk);
    chk("reset_scl", i2c_scl, 1);
    chk("reset_sda", i2c_sda, 1);
    chk("reset_busy", busy, 0);
    chk("reset_end", i2c_end, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_ack_err", ack_err, 0);
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);

    run_xfer(1'b0, 16'h0041, 8'h80, 8'h00, -1, 1'b0);
    run_xfer(1'b1, 16'h0041, 8'h00, 8'hA5, -1, 1'b0);
    run_xfer(1'b1, 16'h0042, 8'h00, 8'h3C, 0, 1'b0);
    run_xfer(1'b0, 16'h0041, 8'h80, 8'h00, -1, 1'b1);
    reset_mid_write();
    run_xfer(1'b0, 16'h00C3, 8'h5A, 8'h00, -1, 1'b0);

    for (int i = 0; i < 16; i++) begin
      int nk;
      nk = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2)) : -1;
      run_xfer(i[0], 16'($urandom), 8'($urandom), 8'($urandom), nk, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
